// File: rtl/vtg_pkg.sv
// vtg_pkg: shared constants for the video timing / pattern generator.
// Holds pattern-mode codes, the colour-bar palette and the moving-bar width.
package vtg_pkg;

    localparam logic [2:0] MODE_BARS   = 3'd0;
    localparam logic [2:0] MODE_GRID   = 3'd1;
    localparam logic [2:0] MODE_GRAD   = 3'd2;
    localparam logic [2:0] MODE_SOLID  = 3'd3;
    localparam logic [2:0] MODE_MOVBAR = 3'd4;

    localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COL_GREEN   = 24'h00FF00;
    localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COL_RED     = 24'hFF0000;
    localparam logic [23:0] COL_BLUE    = 24'h0000FF;
    localparam logic [23:0] COL_BLACK   = 24'h000000;

    localparam int BAR_W = 32;

    // Index 8 and above is the remainder region past the last bar.
    function automatic logic [23:0] bar_colour(input logic [3:0] idx);
        case (idx)
            4'd0:    return COL_WHITE;
            4'd1:    return COL_YELLOW;
            4'd2:    return COL_CYAN;
            4'd3:    return COL_GREEN;
            4'd4:    return COL_MAGENTA;
            4'd5:    return COL_RED;
            4'd6:    return COL_BLUE;
            default: return COL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vtg_counter.sv
// vtg_counter: one wrapping raster counter with sync/active window decode.
// Ports: clk_i/rst_ni, en_i (advance), total/sync/bporch/res timing in;
// cnt_o, wrap_o (at last count), sync_o, act_o, coord_o (cnt - window start).
module vtg_counter #(
    parameter int CNT_W = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [CNT_W-1:0] total_i,
    input  logic [CNT_W-1:0] sync_i,
    input  logic [CNT_W-1:0] bporch_i,
    input  logic [CNT_W-1:0] res_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             wrap_o,
    output logic             sync_o,
    output logic             act_o,
    output logic [CNT_W-1:0] coord_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   start, stop, nxt, cnt_w;

    assign cnt_w  = {1'b0, cnt_q};
    assign start  = {1'b0, sync_i} + {1'b0, bporch_i};
    assign stop   = start + {1'b0, res_i};
    assign nxt    = cnt_w + (CNT_W+1)'(1);

    // A zero total parks the counter at 0 and never reports a wrap.
    assign wrap_o = (total_i != '0) && (nxt >= {1'b0, total_i});

    always_comb begin
        cnt_d = cnt_q;
        if (total_i == '0) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = wrap_o ? '0 : nxt[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign sync_o  = cnt_q < sync_i;
    assign act_o   = (cnt_w >= start) && (cnt_w < stop);
    assign coord_o = cnt_q - start[CNT_W-1:0];

endmodule

// File: rtl/vtg_pattern_gen.sv
// vtg_pattern_gen: parametrised video timing and test-pattern generator.
// Ports: I_pxl_clk, I_rst_n, h/v timing, sync polarities, I_mode, I_solid_rgb
// in; O_de/O_hs/O_vs, O_data_r/g/b, O_x/O_y, O_frame_start, O_fps_toggle out.
// Optional macro VTG_BORDER_EN forces a white 1-pixel frame border.
module vtg_pattern_gen #(
    parameter int CNT_W     = 12,
    parameter int FPS_DIV   = 60,
    parameter int GRID_LOG2 = 5,
    parameter int BAR_STEP  = 4
) (
    input  logic             I_pxl_clk,
    input  logic             I_rst_n,
    input  logic [CNT_W-1:0] I_h_total,
    input  logic [CNT_W-1:0] I_h_sync,
    input  logic [CNT_W-1:0] I_h_bporch,
    input  logic [CNT_W-1:0] I_h_res,
    input  logic [CNT_W-1:0] I_v_total,
    input  logic [CNT_W-1:0] I_v_sync,
    input  logic [CNT_W-1:0] I_v_bporch,
    input  logic [CNT_W-1:0] I_v_res,
    input  logic             I_hs_pol,
    input  logic             I_vs_pol,
    input  logic [2:0]       I_mode,
    input  logic [23:0]      I_solid_rgb,
    output logic             O_de,
    output logic             O_hs,
    output logic             O_vs,
    output logic [7:0]       O_data_r,
    output logic [7:0]       O_data_g,
    output logic [7:0]       O_data_b,
    output logic [CNT_W-1:0] O_x,
    output logic [CNT_W-1:0] O_y,
    output logic             O_frame_start,
    output logic             O_fps_toggle
);
    import vtg_pkg::*;

    localparam int FW = (FPS_DIV > 1) ? $clog2(FPS_DIV) : 1;

    logic [CNT_W-1:0] h_cnt, v_cnt, h_coord, v_coord;
    logic             h_wrap, v_wrap, hs_raw, vs_raw, h_act, v_act;
    logic             origin, de_raw, frame_end;

    logic [CNT_W-1:0] h_total_q, h_sync_q, h_bporch_q, h_res_q;
    logic [CNT_W-1:0] v_total_q, v_sync_q, v_bporch_q, v_res_q;
    logic             hs_pol_q, vs_pol_q;
    logic [2:0]       mode_q;
    logic [23:0]      solid_q;

    logic [CNT_W-1:0] h_total_c, h_sync_c, h_bporch_c, h_res_c;
    logic [CNT_W-1:0] v_total_c, v_sync_c, v_bporch_c, v_res_c;
    logic             hs_pol_c, vs_pol_c;
    logic [2:0]       mode_c;
    logic [23:0]      solid_c;

    assign origin = (h_cnt == '0) && (v_cnt == '0);

    // On the origin cycle the live inputs already govern decode, so the
    // shadow load and its first use happen together (no stale first pixel).
    assign h_total_c  = origin ? I_h_total   : h_total_q;
    assign h_sync_c   = origin ? I_h_sync    : h_sync_q;
    assign h_bporch_c = origin ? I_h_bporch  : h_bporch_q;
    assign h_res_c    = origin ? I_h_res     : h_res_q;
    assign v_total_c  = origin ? I_v_total   : v_total_q;
    assign v_sync_c   = origin ? I_v_sync    : v_sync_q;
    assign v_bporch_c = origin ? I_v_bporch  : v_bporch_q;
    assign v_res_c    = origin ? I_v_res     : v_res_q;
    assign hs_pol_c   = origin ? I_hs_pol    : hs_pol_q;
    assign vs_pol_c   = origin ? I_vs_pol    : vs_pol_q;
    assign mode_c     = origin ? I_mode      : mode_q;
    assign solid_c    = origin ? I_solid_rgb : solid_q;

    vtg_counter #(.CNT_W(CNT_W)) u_hcnt (
        .clk_i    (I_pxl_clk),
        .rst_ni   (I_rst_n),
        .en_i     (1'b1),
        .total_i  (h_total_c),
        .sync_i   (h_sync_c),
        .bporch_i (h_bporch_c),
        .res_i    (h_res_c),
        .cnt_o    (h_cnt),
        .wrap_o   (h_wrap),
        .sync_o   (hs_raw),
        .act_o    (h_act),
        .coord_o  (h_coord)
    );

    vtg_counter #(.CNT_W(CNT_W)) u_vcnt (
        .clk_i    (I_pxl_clk),
        .rst_ni   (I_rst_n),
        .en_i     (h_wrap),
        .total_i  (v_total_c),
        .sync_i   (v_sync_c),
        .bporch_i (v_bporch_c),
        .res_i    (v_res_c),
        .cnt_o    (v_cnt),
        .wrap_o   (v_wrap),
        .sync_o   (vs_raw),
        .act_o    (v_act),
        .coord_o  (v_coord)
    );

    assign de_raw    = h_act & v_act;
    assign frame_end = h_wrap & v_wrap;

    logic [CNT_W-1:0] x_c, y_c;
    assign x_c = de_raw ? h_coord : '0;
    assign y_c = de_raw ? v_coord : '0;

    // Colour bars: pixel-within-bar counter plus bar index, restarted at x==0.
    logic [CNT_W-1:0] bar_w, pix_q, pix_d, pix_c;
    logic [3:0]       idx_q, idx_d, idx_c;

    assign bar_w = h_res_c >> 3;
    assign idx_c = (h_coord == '0) ? 4'd0 : idx_q;
    assign pix_c = (h_coord == '0) ? '0 : pix_q;

    always_comb begin
        idx_d = idx_q;
        pix_d = pix_q;
        if (h_act) begin
            if (pix_c + CNT_W'(1) >= bar_w) begin
                pix_d = '0;
                idx_d = (idx_c == 4'd8) ? idx_c : idx_c + 4'd1;
            end else begin
                pix_d = pix_c + CNT_W'(1);
                idx_d = idx_c;
            end
        end
    end

    // Moving bar position advances on the last pixel of each frame.
    logic [CNT_W-1:0] pos_q, pos_d;
    logic [CNT_W:0]   pos_nxt;
    logic             on_bar;

    assign pos_nxt = {1'b0, pos_q} + (CNT_W+1)'(BAR_STEP);
    assign pos_d   = !frame_end ? pos_q :
                     (pos_nxt >= {1'b0, h_res_c}) ? '0 : pos_nxt[CNT_W-1:0];
    assign on_bar  = ({1'b0, x_c} >= {1'b0, pos_q}) &&
                     ({1'b0, x_c} < {1'b0, pos_q} + (CNT_W+1)'(BAR_W));

    logic [23:0] pat;

    always_comb begin
        pat = COL_BLACK;
        case (mode_c)
            MODE_BARS:   pat = (bar_w == '0) ? COL_BLACK : bar_colour(idx_c);
            MODE_GRID:   pat = (x_c[GRID_LOG2-1:0] == '0 ||
                                y_c[GRID_LOG2-1:0] == '0) ? COL_WHITE : COL_BLACK;
            MODE_GRAD:   pat = {x_c[7:0], x_c[7:0], x_c[7:0]};
            MODE_SOLID:  pat = solid_c;
            MODE_MOVBAR: pat = on_bar ? COL_WHITE : COL_BLUE;
            default:     pat = COL_BLACK;
        endcase
`ifdef VTG_BORDER_EN
        if (x_c == '0 || x_c == h_res_c - CNT_W'(1) ||
            y_c == '0 || y_c == v_res_c - CNT_W'(1)) begin
            pat = COL_WHITE;
        end
`endif
        if (!de_raw) begin
            pat = COL_BLACK;
        end
    end

    logic [FW-1:0]    fcnt_q;
    logic             de_q, hs_q, vs_q, fs_q, tog_q;
    logic [23:0]      rgb_q;
    logic [CNT_W-1:0] x_q, y_q;

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            h_total_q  <= '0;
            h_sync_q   <= '0;
            h_bporch_q <= '0;
            h_res_q    <= '0;
            v_total_q  <= '0;
            v_sync_q   <= '0;
            v_bporch_q <= '0;
            v_res_q    <= '0;
            hs_pol_q   <= 1'b0;
            vs_pol_q   <= 1'b0;
            mode_q     <= '0;
            solid_q    <= '0;
            idx_q      <= '0;
            pix_q      <= '0;
            pos_q      <= '0;
            fcnt_q     <= '0;
            de_q       <= 1'b0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            rgb_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            fs_q       <= 1'b0;
            tog_q      <= 1'b0;
        end else begin
            h_total_q  <= h_total_c;
            h_sync_q   <= h_sync_c;
            h_bporch_q <= h_bporch_c;
            h_res_q    <= h_res_c;
            v_total_q  <= v_total_c;
            v_sync_q   <= v_sync_c;
            v_bporch_q <= v_bporch_c;
            v_res_q    <= v_res_c;
            hs_pol_q   <= hs_pol_c;
            vs_pol_q   <= vs_pol_c;
            mode_q     <= mode_c;
            solid_q    <= solid_c;
            idx_q      <= idx_d;
            pix_q      <= pix_d;
            pos_q      <= pos_d;
            if (origin) begin
                if (fcnt_q == FW'(FPS_DIV - 1)) begin
                    fcnt_q <= '0;
                    tog_q  <= ~tog_q;
                end else begin
                    fcnt_q <= fcnt_q + FW'(1);
                end
            end
            de_q  <= de_raw;
            hs_q  <= ~(hs_raw ^ hs_pol_c);
            vs_q  <= ~(vs_raw ^ vs_pol_c);
            rgb_q <= pat;
            x_q   <= x_c;
            y_q   <= y_c;
            fs_q  <= origin;
        end
    end

    assign O_de          = de_q;
    assign O_hs          = hs_q;
    assign O_vs          = vs_q;
    assign O_data_r      = rgb_q[23:16];
    assign O_data_g      = rgb_q[15:8];
    assign O_data_b      = rgb_q[7:0];
    assign O_x           = x_q;
    assign O_y           = y_q;
    assign O_frame_start = fs_q;
    assign O_fps_toggle  = tog_q;

endmodule
